fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly downstream of the program counter register. It accepts a PC over a valid/ready handshake and issues one instruction-memory request per PC. It buffers each returned instruction with its PC in a small FIFO and presents them to decode over a valid/ready handshake. It also handles misaligned PCs and pipeline flush on branch/jump redirect.

Parameters:
XLEN, 32, address/data width
DEPTH, 2, output FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset, sampled on posedge clk
pc_in  in  XLEN  PC from program counter register
pc_valid  in  1  pc_in is valid
pc_ready  out  1  fetch unit accepts pc_in this cycle (parent holds PC when low)
imem_req_valid  out  1  memory request valid
imem_req_addr  out  XLEN  memory request word address (byte address, [1:0]=0)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  response data valid
imem_resp_data  in  XLEN  fetched instruction word
instr_valid  out  1  FIFO head valid
instr_data  out  XLEN  FIFO head instruction
instr_pc  out  XLEN  FIFO head PC
instr_misaligned  out  1  FIFO head came from misaligned PC
instr_ready  in  1  decode consumes head
flush  in  1  discard all buffered and in-flight fetches

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Reset values:
  - state IDLE; FIFO count, rd_ptr and wr_ptr all 0; drop flag 0; all FIFO storage 0.
  - Outputs: instr_valid=0, imem_req_valid=0, instr_data/instr_pc/instr_misaligned=0.
  - pc_ready forced 0 while reset is high.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req_valid=1, address held.
  - WAIT: request accepted, awaiting response.
- pc_ready = (state==IDLE) && (count<DEPTH) && !flush && !reset. Accept = pc_valid && pc_ready.
- Aligned accept (pc_in[1:0]==0):
  - Latch the PC and go to REQ.
  - REQ -> WAIT on imem_req_ready.
  - WAIT -> IDLE on imem_resp_valid; push {pc, imem_resp_data, 0} unless the drop flag is set.
- Misaligned accept (pc_in[1:0]!=0):
  - No memory request; push {pc_in, 0, 1} on the same edge; stay IDLE.
- Request rules: once imem_req_valid is asserted, it and imem_req_addr hold stable until imem_req_ready, including across a flush. At most one request outstanding.
- Response rules: imem_resp_valid outside WAIT is ignored.
- FIFO space is reserved at accept (count<DEPTH, no other push until the response returns), so a response push never overflows.
- Latency, zero-wait memory: PC accepted at edge N -> imem_req_valid during cycle N+1 -> response during N+2 -> instr_valid during N+3. Misaligned: instr_valid during N+1.
- Output side:
  - instr_valid = (count!=0); the head is registered storage at rd_ptr.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- flush:
  - On the edge where flush=1, count, rd_ptr and wr_ptr go to 0; a simultaneous pop or push is ignored.
  - If state is REQ or WAIT, or a response arrives that same cycle, set the drop flag. The pending response is consumed without a push, then the flag clears on WAIT->IDLE.
  - A flush arriving in the same cycle as a fresh accept cannot happen: pc_ready=0 when flush=1.
- Reset mid-operation: reset overrides everything, including an outstanding request. The memory side must be reset together with this block.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN constant.
  - fetch_entry_t struct {pc, instr, misaligned}.
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - NOP_INSTR constant 32'h00000013, reserved for decode use.
- One sub-module, fetch_fifo (DEPTH entries of fetch_entry_t):
  - Ports: push, pop, clear, full, empty, count, head.
  - Synchronous reset, pointer wrap.
- fetch_unit contains the FSM, drop flag and handshake logic.

Test Plan:
- Reset: hold reset 2 cycles with pc_valid=1 -> pc_ready=0, imem_req_valid=0, instr_valid=0. The cycle after release, pc_ready=1.
- Single fetch: pc_in=0x00000004, imem_req_ready=1, resp next cycle with 0x00500093 -> imem_req_addr=0x4 at N+1. At N+3: instr_valid=1, instr_pc=0x4, instr_data=0x00500093, instr_misaligned=0.
- Backpressure: DEPTH=2, instr_ready=0, fetch 0x0 then 0x4 -> after the second push pc_ready=0, count=2. Pulse instr_ready one cycle -> head becomes pc 0x4, pc_ready=1 next cycle.
- Misaligned: pc_in=0x00000006 -> imem_req_valid stays 0. Next cycle instr_valid=1, instr_pc=0x6, instr_misaligned=1, instr_data=0.
- Flush in flight: accept 0x10, assert flush during WAIT, resp 0xDEADBEEF arrives two cycles later -> never visible, instr_valid stays 0. Then fetch 0x40 -> delivered normally.
- Request stall: imem_req_ready=0 for 3 cycles with flush pulsed in cycle 2 -> imem_req_valid=1 and addr=0x20 stable all 3 cycles. The subsequent response is dropped and count stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry widths follow XLEN below; fetch_unit must be built with the same XLEN.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the PC, instruction-memory and decode handshakes around the fetch stage.
// master = fetch unit, slave = its surroundings (PC register, memory, decode).
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  logic            instr_valid;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_misaligned;
  logic            instr_ready;

  logic            flush;

  modport master (
    input  pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready, flush,
    output pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data,
           instr_pc, instr_misaligned
  );

  modport slave (
    output pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready, flush,
    input  pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data,
           instr_pc, instr_misaligned
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small register-based FIFO of fetch entries; head is read straight from storage.
// clear empties the FIFO in one cycle and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               wr_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset too so the head reads as all-zero after reset;
      // it is only a few flops, so this costs almost nothing here.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one memory request per aligned PC, direct push for
// misaligned PCs, results buffered for decode; flush drops buffered and in-flight work.
module fetch_unit #(
  parameter int XLEN  = fetch_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic [XLEN-1:0]      pc_q;
  logic                 drop;
  logic                 accept;
  logic                 misaligned;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;

  // A slot is reserved at accept: no new PC while a fetch is outstanding or the FIFO is full.
  assign bus.pc_ready        = (state == IDLE) && !full && !bus.flush && !reset;
  assign accept              = bus.pc_valid && bus.pc_ready;
  assign misaligned          = (bus.pc_in[1:0] != 2'b00);

  assign bus.imem_req_valid  = (state == REQ);
  assign bus.imem_req_addr   = {pc_q[XLEN-1:2], 2'b00};

  assign bus.instr_valid      = (count != '0);
  assign bus.instr_data       = head.instr;
  assign bus.instr_pc         = head.pc;
  assign bus.instr_misaligned = head.misaligned;
  assign pop                  = !empty && bus.instr_ready;

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates see pre-edge values.
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !misaligned) pc_q <= bus.pc_in;
      // The response that ends WAIT is the one being dropped, so clearing wins.
      if (state == WAIT && bus.imem_resp_valid) drop <= 1'b0;
      else if (bus.flush && state != IDLE)     drop <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_next = state;
    push       = 1'b0;
    push_entry = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            push       = 1'b1;
            push_entry = '{pc: bus.pc_in, instr: '0, misaligned: 1'b1};
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (bus.imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          state_next = IDLE;
          push       = !drop;
          push_entry = '{pc: pc_q, instr: bus.imem_resp_data, misaligned: 1'b0};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .clear   (bus.flush),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// all compared against a queue-based transaction model of the fetch stage.
module tb_fetch_unit;

  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic reset;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN  (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents, plus the single outstanding fetch, if any.
  fetch_entry_t mq[$];
  bit           m_out;
  bit           m_req_pend;
  bit           m_drop;
  logic [31:0]  m_pc;
  int           resp_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_out      = 1'b0;
    m_req_pend = 1'b0;
    m_drop     = 1'b0;
    m_pc       = '0;
    resp_delay = 0;
  endtask

  // One clock cycle: drive inputs at negedge, compare outputs, advance the model, pass the edge.
  task automatic step(input logic pv, input logic [31:0] pc, input logic rq_rdy,
                      input logic rsp_v, input logic [31:0] rsp_d,
                      input logic ir, input logic fl);
    bit           exp_rdy;
    bit           exp_req;
    bit           accept;
    bit           resp;
    bit           req_acc;
    bit           pop;
    bit           do_push;
    fetch_entry_t item;
    @(negedge clk);
    bus.pc_valid        = pv;
    bus.pc_in           = pc;
    bus.imem_req_ready  = rq_rdy;
    bus.imem_resp_valid = rsp_v;
    bus.imem_resp_data  = rsp_d;
    bus.instr_ready     = ir;
    bus.flush           = fl;
    #1;
    exp_rdy = !m_out && (mq.size() < DEPTH) && !fl;
    exp_req = m_out && m_req_pend;
    check("pc_ready", 32'(bus.pc_ready), 32'(exp_rdy));
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", bus.imem_req_addr, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("instr_pc", bus.instr_pc, mq[0].pc);
      check("instr_data", bus.instr_data, mq[0].instr);
      check("instr_mis", 32'(bus.instr_misaligned), 32'(mq[0].misaligned));
    end

    accept  = pv && exp_rdy;
    resp    = m_out && !m_req_pend && rsp_v;
    req_acc = exp_req && rq_rdy;
    pop     = (mq.size() != 0) && ir;
    do_push = 1'b0;
    item    = '0;
    if (accept && pc[1:0] != 2'b00) begin
      do_push = 1'b1;
      item    = '{pc, 32'h0, 1'b1};
    end
    if (resp && !m_drop) begin
      do_push = 1'b1;
      item    = '{m_pc, rsp_d, 1'b0};
    end
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(item);
    end
    if (resp) begin
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (fl && m_out) begin
      m_drop = 1'b1;
    end
    if (req_acc) begin
      m_req_pend = 1'b0;
      resp_delay = $urandom_range(0, 2);
    end else if (m_out && !m_req_pend && !resp && resp_delay > 0) begin
      resp_delay--;
    end
    if (accept && pc[1:0] == 2'b00) begin
      m_out      = 1'b1;
      m_req_pend = 1'b1;
      m_pc       = pc;
    end
    @(posedge clk);
  endtask

  // Aligned fetch with a zero-wait memory and decode holding off.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    step(1'b1, pc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset               = 1'b1;
    bus.pc_valid        = 1'b1;
    bus.pc_in           = 32'h8;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.instr_ready     = 1'b0;
    bus.flush           = 1'b0;
    #1;
    check("rst_pc_ready_pre", 32'(bus.pc_ready), 32'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_pc_ready", 32'(bus.pc_ready), 32'h0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      check("rst_instr_data", bus.instr_data, 32'h0);
      check("rst_instr_pc", bus.instr_pc, 32'h0);
      check("rst_instr_mis", 32'(bus.instr_misaligned), 32'h0);
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.pc_valid = 1'b0;
    model_clear();
  endtask

  task automatic random_traffic(input int cycles);
    logic [31:0] r;
    logic [31:0] pc;
    logic        pv;
    logic        rsp_v;
    for (int i = 0; i < cycles; i++) begin
      r  = $urandom();
      pv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) pc = {r[31:2], 2'($urandom_range(1, 3))};
      else                           pc = {r[31:2], 2'b00};
      if (m_out && !m_req_pend) rsp_v = (resp_delay == 0);
      else                      rsp_v = ($urandom_range(0, 7) == 0);
      step(pv, pc, $urandom_range(0, 2) != 0, rsp_v, $urandom(),
           1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    model_clear();

    do_reset(2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Single fetch, zero-wait memory.
    fetch(32'h4, 32'h0050_0093);
    #1;
    check("single_valid", 32'(bus.instr_valid), 32'h1);
    check("single_pc", bus.instr_pc, 32'h4);
    check("single_data", bus.instr_data, 32'h0050_0093);
    check("single_mis", 32'(bus.instr_misaligned), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: FIFO fills, one pop frees a slot.
    fetch(32'h0, 32'h1111_1111);
    fetch(32'h4, 32'h2222_2222);
    step(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("bp_head_pc", bus.instr_pc, 32'h4);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Misaligned PC bypasses memory.
    step(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("mis_valid", 32'(bus.instr_valid), 32'h1);
    check("mis_pc", bus.instr_pc, 32'h6);
    check("mis_flag", 32'(bus.instr_misaligned), 32'h1);
    check("mis_data", bus.instr_data, 32'h0);
    check("mis_no_req", 32'(bus.imem_req_valid), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while waiting for a response.
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    #1;
    check("flush_dropped", 32'(bus.instr_valid), 32'h0);
    fetch(32'h40, 32'h0BAD_F00D);
    #1;
    check("after_flush_pc", bus.instr_pc, 32'h40);
    check("after_flush_data", bus.instr_data, 32'h0BAD_F00D);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Request stall with a flush in the middle: request must hold, response dropped.
    step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    #1;
    check("stall_dropped", 32'(bus.instr_valid), 32'h0);

    random_traffic(2000);
    do_reset(1);
    fetch(32'h100, 32'hCAFE_0001);
    #1;
    check("post_reset_pc", bus.instr_pc, 32'h100);
    random_traffic(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
